opl3_i2s_tx: RTL
================

Name: opl3_i2s_tx

Overview:
- Consumes the stereo mix emitted by the DAC-prep stage that follows channel accumulation: sample_valid, sample_l, sample_r.
- Buffers samples in a 2-entry FIFO and serializes them as standard I2S (BCLK, LRCLK, SDATA) toward an external codec.
- Generates all serial clocks by dividing clk.
- Reports FIFO underrun/overflow via saturating counters for debug.

Parameters:
- SAMPLE_WIDTH, DAC_OUTPUT_WIDTH (from opl3_pkg): width of incoming signed samples; must be < SLOT_WIDTH.
- SLOT_WIDTH, 32: BCLK periods per channel slot; frame = 2*SLOT_WIDTH BCLK periods.
- CLK_DIV, 4: clk cycles per BCLK half-period; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is in this single domain.
- reset_n  input  1  synchronous, active-low reset.
- sample_valid  input  1  one-cycle pulse; sample_l/sample_r are valid in that cycle.
- sample_l  input  SAMPLE_WIDTH  signed left sample.
- sample_r  input  SAMPLE_WIDTH  signed right sample.
- i2s_bclk  output  1  bit clock.
- i2s_lrclk  output  1  word select; 0 = left slot, 1 = right slot.
- i2s_sdata  output  1  serial data, MSB first.
- underrun_cnt  output  8  saturating count of frames started with an empty FIFO.
- overflow_cnt  output  8  saturating count of samples dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0 at a clk edge), registered values:
  - i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0.
  - Both counters 0.
  - FIFO empty; held sample = 0.
  - Divider count 0; bit counter = 2*SLOT_WIDTH-1.
- Mid-operation reset discards FIFO contents and any partial frame. No glitch beyond the registered return to reset values.
- Divider: counts 0..CLK_DIV-1. At terminal count, i2s_bclk toggles.
  - 1->0 transition ("fall event"): bit counter advances, wrapping 2*SLOT_WIDTH-1 -> 0.
  - i2s_lrclk and i2s_sdata update only on fall events, in the same clk edge as i2s_bclk goes low.
- i2s_lrclk = (bit counter >= SLOT_WIDTH).
- Frame load, on the fall event where the bit counter wraps to 0:
  - FIFO non-empty: pop head into the frame shift register and record it as the held sample.
  - FIFO empty: reload the held sample (repeat) and increment underrun_cnt, saturating at 255.
- Slot bit index j = bitcounter mod SLOT_WIDTH; S is the current slot's sample (left when lrclk=0, right when lrclk=1).
  - j=0: sdata=0. This is the I2S one-bit delay.
  - 1<=j<=SAMPLE_WIDTH: sdata = S[SAMPLE_WIDTH-j].
  - j > SAMPLE_WIDTH: sdata = 0 (zero padding).
- FIFO, 2 entries of {l,r}:
  - Push when sample_valid=1 and not full.
  - sample_valid=1 while full: sample dropped, FIFO unchanged, overflow_cnt++ (saturating).
  - Push and pop in the same cycle on a full FIFO: pop happens, push accepted, no overflow counted.
  - Push and pop in the same cycle on an empty FIFO: no bypass; the pop sees empty and counts an underrun, and the pushed sample is stored.
- Latency: a pushed sample appears at the next frame start, i.e. at most one frame plus one fall event.

Optional Feature:
- Macro: OPL3_I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format, no one-bit delay.
  - 0<=j<SAMPLE_WIDTH: sdata = S[SAMPLE_WIDTH-1-j].
  - Otherwise sdata = 0.
  - i2s_lrclk polarity is inverted: 1 = left slot.
- Undefined: standard I2S as in Behaviour.

Decomposition:
- opl3_pkg gains:
  - I2S_SLOT_WIDTH constant (32).
  - typedef stereo_sample_t, packed {signed [DAC_OUTPUT_WIDTH-1:0] l, r}.
- One sub-module, opl3_i2s_sample_fifo: 2-deep stereo_sample_t FIFO.
  - Interface: push/pop/full/empty.
  - Implements the overflow-drop rule.
- Divider, bit counter, shift/serialize logic and the counters stay in the top module.

Test Plan (CLK_DIV=2, SLOT_WIDTH=32, SAMPLE_WIDTH=24; frame = 256 clk):
- Reset release, no samples -> bclk period 4 clk, lrclk period 256 clk; sdata all 0; underrun_cnt reaches 1 at the first frame start, then +1 per frame.
- Push l=24'h800001, r=24'h7FFFFE before frame start -> left slot: bit j=0 is 0, bits j=1..24 are 1000_0000_0000_0000_0000_0001, j=25..31 are 0; right slot carries 7FFFFE with the same framing.
- Push 3 samples within one frame -> first two held, third dropped; overflow_cnt=1; next two frames carry samples 1 and 2; third frame repeats sample 2 and increments underrun_cnt.
- 300 consecutive underrun frames -> underrun_cnt saturates at 255; 300 overflowing pushes -> overflow_cnt saturates at 255.
- Assert reset_n=0 mid right slot for 1 clk -> next edge: bclk=0, lrclk=1, sdata=0, counters 0, FIFO empty; clean restart.
- Rebuilt with OPL3_I2S_LEFT_JUSTIFIED_EN, l=24'hA5A5A5 -> MSB at j=0 while lrclk=1; bits j=24..31 zero.

Source files
------------

// File: rtl/opl3_pkg.sv
// opl3_pkg: constants and types shared along the OPL3 output path.
// Covers the DAC sample width, the I2S slot width and the stereo sample record.
package opl3_pkg;

  localparam int DAC_OUTPUT_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH   = 32;

  typedef struct packed {
    logic signed [DAC_OUTPUT_WIDTH-1:0] l;
    logic signed [DAC_OUTPUT_WIDTH-1:0] r;
  } stereo_sample_t;

  // Debug counters hold at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/opl3_i2s_sample_fifo.sv
// opl3_i2s_sample_fifo: 2-deep stereo sample FIFO between the mixer and the I2S serializer.
// A push on a full FIFO is dropped unless a pop frees an entry in the same cycle.
module opl3_i2s_sample_fifo
  import opl3_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push_i,
  input  stereo_sample_t push_data_i,
  input  logic           pop_i,
  output stereo_sample_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  stereo_sample_t mem_q [2];
  logic           wrPtr_q, wrPtr_d;
  logic           rdPtr_q, rdPtr_d;
  logic [1:0]     count_q, count_d;
  logic           doPush, doPop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rdPtr_q];

  // Pop is evaluated first, so a full FIFO popped this cycle still accepts the push.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = ~wrPtr_q;
    if (doPop)  rdPtr_d = ~rdPtr_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= push_data_i;
  end

endmodule

// File: rtl/opl3_i2s_tx.sv
// opl3_i2s_tx: buffers the stereo mix and serializes it as I2S with clocks divided from clk.
// Define OPL3_I2S_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay, lrclk=1 selects left).
module opl3_i2s_tx
  import opl3_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DAC_OUTPUT_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
  parameter int CLK_DIV      = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_l,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_r,
  output logic                           i2s_bclk,
  output logic                           i2s_lrclk,
  output logic                           i2s_sdata,
  output logic [7:0]                     underrun_cnt,
  output logic [7:0]                     overflow_cnt
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam int DCW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SIW        = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  logic [DCW-1:0]          div_q, div_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic [BCW-1:0]          bitCnt_q, bitCnt_d;
  stereo_sample_t          frame_q, frame_d;
  logic [7:0]              underrun_q, underrun_d;
  logic [7:0]              overflow_q, overflow_d;

  stereo_sample_t          pushData, fifoHead;
  logic                    fifoPop, fifoFull, fifoEmpty;
  logic                    fallEvent, rightSlot;
  logic [SAMPLE_WIDTH-1:0] slotSample;
  int                      slotBit;

  assign pushData = '{l: sample_l, r: sample_r};

  opl3_i2s_sample_fifo u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (sample_valid),
    .push_data_i (pushData),
    .pop_i       (fifoPop),
    .head_o      (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  // frame_q doubles as the held sample that is repeated whenever a frame starts with an empty FIFO.
  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    bitCnt_d   = bitCnt_q;
    frame_d    = frame_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    fifoPop    = 1'b0;
    fallEvent  = 1'b0;
    rightSlot  = 1'b0;
    slotSample = '0;
    slotBit    = 0;

    if (sample_valid && fifoFull && !fifoPop) overflow_d = sat_inc8(overflow_q);

    if (div_q == DCW'(CLK_DIV - 1)) begin
      div_d     = '0;
      bclk_d    = ~bclk_q;
      fallEvent = bclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (fallEvent) begin
      bitCnt_d = (bitCnt_q == BCW'(FRAME_BITS - 1)) ? '0 : bitCnt_q + 1'b1;
      if (bitCnt_d == '0) begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          frame_d = fifoHead;
        end else begin
          underrun_d = sat_inc8(underrun_q);
        end
      end

      // Serialize from the next-state frame so the first bit of a new frame is already correct.
      rightSlot  = (bitCnt_d >= BCW'(SLOT_WIDTH));
      slotSample = rightSlot ? frame_d.r : frame_d.l;
      slotBit    = int'(bitCnt_d) % SLOT_WIDTH;
`ifdef OPL3_I2S_LEFT_JUSTIFIED_EN
      lrclk_d = ~rightSlot;
      if (slotBit < SAMPLE_WIDTH) sdata_d = slotSample[SIW'(SAMPLE_WIDTH - 1 - slotBit)];
      else                        sdata_d = 1'b0;
`else
      lrclk_d = rightSlot;
      if (slotBit >= 1 && slotBit <= SAMPLE_WIDTH) sdata_d = slotSample[SIW'(SAMPLE_WIDTH - slotBit)];
      else                                         sdata_d = 1'b0;
`endif
    end

    if (sample_valid && fifoFull && fifoPop) overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      bitCnt_q   <= BCW'(FRAME_BITS - 1);
      frame_q    <= '0;
      underrun_q <= 8'd0;
      overflow_q <= 8'd0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      bitCnt_q   <= bitCnt_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign underrun_cnt = underrun_q;
  assign overflow_cnt = overflow_q;

endmodule
